load_store_unit: RTL and testbench

Stage-3 memory responder for the 3-stage RISC-V core. It consumes the registered memory controls from the stage 2→3 pipeline register: `rd_en`, `wr_en`, ALU result as address, rs2 as store data, and funct3. It then performs the access on the single-outstanding data bus and holds the pipeline with `stall_o` until the access completes. Load data is returned aligned and extended for the writeback mux; misalignment and bus timeouts are reported to the CSR/trap logic.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and memory: a single-outstanding
// request/grant channel plus a read-data return.
//
// Handshake: bus_req_o is a valid that is held, with address, enables, write
// flag and data unchanged, until the cycle in which bus_gnt_i is also high.
// That cycle transfers the request. Read data arrives later, as a one-cycle
// bus_rvalid_i pulse carrying bus_rdata_i, at least one cycle after grant.
interface load_store_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: stage-3 memory responder. It takes the registered load/store
// controls, runs one access on the data bus, stalls the pipeline until the
// access finishes, and returns the extended load result or an access fault.
// Optional feature: define MISALIGNED_SPLIT_EN to split word-crossing accesses
// into two bus transfers instead of raising a misalignment fault.
module load_store_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        funct3_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic [2:0]        dbg_state_o,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] cnt_q;
  logic [31:0] addr_q, wdata_q, word0_q;
  logic [2:0]  f3_q;
  logic        we_q;

  // Operands in use: live inputs while IDLE, latched copies afterwards, so the
  // registered bus outputs are identical on entry to REQ1 and while held there.
  logic        idle;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_f3;
  logic        a_we;
  logic [1:0]  off;
  logic        size_w, size_h, uns, misal, split, to_hit, bus_state;
  logic [3:0]  mask, be_lo, be_hi;
  logic [31:0] wd_lo, wd_hi, w0, ld_raw, ld_ext;

  assign idle    = (state_q == IDLE);
  assign a_addr  = idle ? addr_i   : addr_q;
  assign a_wdata = idle ? wdata_i  : wdata_q;
  assign a_f3    = idle ? funct3_i : f3_q;
  assign a_we    = idle ? wr_en_i  : we_q;
  assign off     = a_addr[1:0];

  // funct3: bit 1 set means word (covers the undefined codes), else bit 0 picks half.
  assign size_w = a_f3[1];
  assign size_h = !a_f3[1] && a_f3[0];
  assign uns    = a_f3[2];
  assign mask   = size_w ? 4'hF : (size_h ? 4'h3 : 4'h1);
  assign misal  = (size_h && off[0]) || (size_w && (off != 2'd0));
  assign w0     = (state_q == WAIT1) ? bus.bus_rdata_i : word0_q;

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] word1_q, w1;
  logic [7:0]  be8;
  logic [63:0] wd64;

  // Shift across an 8-lane window: the upper four lanes belong to the next word.
  assign be8    = {4'b0000, mask} << off;
  assign wd64   = {32'b0, a_wdata} << {off, 3'b000};
  assign be_lo  = be8[3:0];
  assign be_hi  = be8[7:4];
  assign wd_lo  = wd64[31:0];
  assign wd_hi  = wd64[63:32];
  assign split  = |be8[7:4];
  assign w1     = (state_q == WAIT2) ? bus.bus_rdata_i : word1_q;
  assign ld_raw = 32'({w1, w0} >> {off, 3'b000});
`else
  assign be_lo  = mask << off;
  assign be_hi  = 4'h0;
  assign wd_lo  = a_wdata << {off, 3'b000};
  assign wd_hi  = 32'h0;
  assign split  = 1'b0;
  assign ld_raw = w0 >> {off, 3'b000};
`endif

  // Sign- or zero-extend the lane-aligned load data to 32 bits.
  always_comb begin
    ld_ext = ld_raw;
    if (!size_w) begin
      if (size_h) ld_ext = uns ? {16'h0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      else        ld_ext = uns ? {24'h0, ld_raw[7:0]}  : {{24{ld_raw[7]}},  ld_raw[7:0]};
    end
  end

  assign bus_state = (state_q == REQ1) || (state_q == WAIT1) ||
                     (state_q == REQ2) || (state_q == WAIT2);
  assign to_hit    = (BUS_TIMEOUT != 0) && (cnt_q == BUS_TIMEOUT - 1);
  assign stall_o   = reset && ((!idle && state_q != DONE) || (idle && (rd_en_i || wr_en_i)));
  assign dbg_state_o = state_q;

  logic        req_n, hi_n, rvalid_n, err_n;
  logic [1:0]  cause_n;
  logic [31:0] rdata_n;

  // Next state and next values of the registered result/fault outputs.
  always_comb begin
    state_n  = state_q;
    rvalid_n = 1'b0;
    err_n    = 1'b0;
    cause_n  = 2'd0;
    rdata_n  = rdata_o;
    case (state_q)
      IDLE: begin
        if (rd_en_i || wr_en_i) begin
`ifdef MISALIGNED_SPLIT_EN
          state_n = REQ1;
`else
          if (misal) begin
            state_n = DONE;
            err_n   = 1'b1;
            cause_n = a_we ? 2'd1 : 2'd0;
          end else begin
            state_n = REQ1;
          end
`endif
        end
      end
      REQ1: begin
        if (bus.bus_gnt_i) begin
          if (a_we) state_n = split ? REQ2 : DONE;
          else      state_n = WAIT1;
        end else if (to_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
          cause_n = 2'd2;
        end
      end
      WAIT1: begin
        if (bus.bus_rvalid_i) begin
          state_n = split ? REQ2 : DONE;
          if (!split) begin
            rvalid_n = 1'b1;
            rdata_n  = ld_ext;
          end
        end else if (to_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
          cause_n = 2'd2;
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      REQ2: begin
        if (bus.bus_gnt_i) begin
          state_n = a_we ? DONE : WAIT2;
        end else if (to_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
          cause_n = 2'd2;
        end
      end
      WAIT2: begin
        if (bus.bus_rvalid_i) begin
          state_n  = DONE;
          rvalid_n = 1'b1;
          rdata_n  = ld_ext;
        end else if (to_hit) begin
          state_n = DONE;
          err_n   = 1'b1;
          cause_n = 2'd2;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_n = (state_n == REQ1) || (state_n == REQ2);
  assign hi_n  = (state_n == REQ2);

  // State, timeout counter, operand latches and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= 32'd0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      f3_q            <= 3'd0;
      we_q            <= 1'b0;
      word0_q         <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
      word1_q         <= 32'd0;
`endif
      rdata_o         <= 32'd0;
      rdata_valid_o   <= 1'b0;
      err_o           <= 1'b0;
      err_cause_o     <= 2'd0;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= 32'd0;
      bus.bus_wdata_o <= 32'd0;
      bus.bus_be_o    <= 4'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= (bus_state && state_n == state_q) ? cnt_q + 32'd1 : 32'd0;
      if (idle && (rd_en_i || wr_en_i)) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        f3_q    <= funct3_i;
        we_q    <= wr_en_i;
      end
      if (state_q == WAIT1 && bus.bus_rvalid_i) word0_q <= bus.bus_rdata_i;
`ifdef MISALIGNED_SPLIT_EN
      if (state_q == WAIT2 && bus.bus_rvalid_i) word1_q <= bus.bus_rdata_i;
`endif
      rdata_o         <= rdata_n;
      rdata_valid_o   <= rvalid_n;
      err_o           <= err_n;
      err_cause_o     <= cause_n;
      bus.bus_req_o   <= req_n;
      bus.bus_we_o    <= req_n && a_we;
      bus.bus_addr_o  <= req_n ? ({a_addr[31:2], 2'b00} + (hi_n ? 32'd4 : 32'd0)) : 32'd0;
      bus.bus_be_o    <= req_n ? (hi_n ? be_hi : be_lo) : 4'd0;
      bus.bus_wdata_o <= req_n ? (hi_n ? wd_hi : wd_lo) : 32'd0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned loads/stores of every size,
// grant back-pressure, misaligned handling (split or fault, following
// MISALIGNED_SPLIT_EN), bus timeout and asynchronous reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, err;
  logic [1:0]  err_cause;
  logic [2:0]  dbg_state;

  load_store_unit_if bus_if();

  load_store_unit #(.BUS_TIMEOUT(4)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .rd_en_i       (rd_en),
    .wr_en_i       (wr_en),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .funct3_i      (funct3),
    .stall_o       (stall),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
    .err_o         (err),
    .err_cause_o   (err_cause),
    .dbg_state_o   (dbg_state),
    .bus           (bus_if)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- checking ----
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every load result pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (reset && rdata_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_valid", 32'(rdata_valid), 32'd0);
      else                   check("sb_rdata", rdata, exp_q.pop_front());
    end
  end

  // ---- drivers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    rd_en  = rd;
    wr_en  = wr;
    addr   = a;
    wdata  = d;
    funct3 = f;
  endtask

  // One single-word access: grant after gnt_delay idle request cycles, read
  // data one cycle after grant.
  task automatic single(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] word, input logic [31:0] exp_rd,
                        input int gnt_delay);
    drive(!we, we, a, d, f);
    if (!we) exp_q.push_back(exp_rd);
    #1;
    check({tag, "_stall_c0"}, 32'(stall), 32'd1);
    check({tag, "_noreq_c0"}, 32'(bus_if.bus_req_o), 32'd0);
    for (int i = 0; i <= gnt_delay; i++) begin
      step();
      check({tag, "_req"}, 32'(bus_if.bus_req_o), 32'd1);
      check({tag, "_addr"}, bus_if.bus_addr_o, {a[31:2], 2'b00});
      check({tag, "_be"}, 32'(bus_if.bus_be_o), 32'(exp_be));
      check({tag, "_we"}, 32'(bus_if.bus_we_o), 32'(we));
      if (we) check({tag, "_wdata"}, bus_if.bus_wdata_o, exp_wd);
    end
    bus_if.bus_gnt_i = 1'b1;
    step();
    bus_if.bus_gnt_i = 1'b0;
    if (!we) begin
      check({tag, "_stall_wait"}, 32'(stall), 32'd1);
      check({tag, "_req_drop"}, 32'(bus_if.bus_req_o), 32'd0);
      bus_if.bus_rvalid_i = 1'b1;
      bus_if.bus_rdata_i  = word;
      step();
      bus_if.bus_rvalid_i = 1'b0;
    end
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_valid_done"}, 32'(rdata_valid), 32'(!we));
    check({tag, "_err_done"}, 32'(err), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
    check({tag, "_idle"}, 32'(dbg_state), 32'd0);
  endtask

  // ---- main sequence ----
  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h100, 32'd0, 3'b010);
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.bus_rdata_i  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(bus_if.bus_req_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_valid", 32'(rdata_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Aligned accesses: tag, we, addr, wdata, funct3, be, bus wdata, bus word, load result, grant delay
    single("lw",  1'b0, 32'h100, 32'h0,        3'b010, 4'hF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0);
    single("lb",  1'b0, 32'h103, 32'h0,        3'b000, 4'h8, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 0);
    single("lbu", 1'b0, 32'h103, 32'h0,        3'b100, 4'h8, 32'h0,        32'h80FF0000, 32'h00000080, 0);
    single("lh",  1'b0, 32'h102, 32'h0,        3'b001, 4'hC, 32'h0,        32'h80017F00, 32'hFFFF8001, 1);
    single("lhu", 1'b0, 32'h102, 32'h0,        3'b101, 4'hC, 32'h0,        32'h80017F00, 32'h00008001, 0);
    single("sh",  1'b1, 32'h102, 32'h1234ABCD, 3'b001, 4'hC, 32'hABCD0000, 32'h0,        32'h0,        3);
    single("sb",  1'b1, 32'h101, 32'h11223355, 3'b000, 4'h2, 32'h22335500, 32'h0,        32'h0,        1);
    single("sw3", 1'b1, 32'h104, 32'hCAFEF00D, 3'b011, 4'hF, 32'hCAFEF00D, 32'h0,        32'h0,        0);

`ifdef MISALIGNED_SPLIT_EN
    // Split load LW 0x101 across 0x100/0x104.
    drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b010);
    exp_q.push_back(32'h55443322);
    #1;
    check("slw_stall_c0", 32'(stall), 32'd1);
    step();
    check("slw_req1", 32'(bus_if.bus_req_o), 32'd1);
    check("slw_addr1", bus_if.bus_addr_o, 32'h100);
    check("slw_be1", 32'(bus_if.bus_be_o), 32'hE);
    bus_if.bus_gnt_i = 1'b1;
    step();
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = 32'h44332211;
    step();
    bus_if.bus_rvalid_i = 1'b0;
    check("slw_req2", 32'(bus_if.bus_req_o), 32'd1);
    check("slw_addr2", bus_if.bus_addr_o, 32'h104);
    check("slw_be2", 32'(bus_if.bus_be_o), 32'h1);
    check("slw_stall2", 32'(stall), 32'd1);
    bus_if.bus_gnt_i = 1'b1;
    step();
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = 32'h88776655;
    step();
    bus_if.bus_rvalid_i = 1'b0;
    check("slw_valid", 32'(rdata_valid), 32'd1);
    check("slw_err", 32'(err), 32'd0);
    check("slw_stall_done", 32'(stall), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();

    // Split store SW 0x103.
    drive(1'b0, 1'b1, 32'h103, 32'hAABBCCDD, 3'b010);
    step();
    check("ssw_addr1", bus_if.bus_addr_o, 32'h100);
    check("ssw_be1", 32'(bus_if.bus_be_o), 32'h8);
    check("ssw_wd1", bus_if.bus_wdata_o, 32'hDD000000);
    bus_if.bus_gnt_i = 1'b1;
    step();
    check("ssw_addr2", bus_if.bus_addr_o, 32'h104);
    check("ssw_be2", 32'(bus_if.bus_be_o), 32'h7);
    check("ssw_wd2", bus_if.bus_wdata_o, 32'h00AABBCC);
    step();
    bus_if.bus_gnt_i = 1'b0;
    check("ssw_stall_done", 32'(stall), 32'd0);
    check("ssw_err", 32'(err), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
`else
    // Misaligned load and store fault without touching the bus.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b010);
      else        drive(1'b0, 1'b1, 32'h103, 32'h5555AAAA, 3'b001);
      #1;
      check("mis_stall_c0", 32'(stall), 32'd1);
      step();
      check("mis_err", 32'(err), 32'd1);
      check("mis_cause", 32'(err_cause), 32'(k));
      check("mis_noreq", 32'(bus_if.bus_req_o), 32'd0);
      check("mis_stall_done", 32'(stall), 32'd0);
      check("mis_valid", 32'(rdata_valid), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      step();
      check("mis_err_pulse", 32'(err), 32'd0);
    end
`endif

    // Timeout: granted load, no read data for 4 cycles in WAIT1.
    drive(1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
    step();
    bus_if.bus_gnt_i = 1'b1;
    step();
    bus_if.bus_gnt_i = 1'b0;
    repeat (3) step();
    check("to_state_wait1", 32'(dbg_state), 32'd2);
    check("to_stall", 32'(stall), 32'd1);
    check("to_no_err_yet", 32'(err), 32'd0);
    step();
    check("to_err", 32'(err), 32'd1);
    check("to_cause", 32'(err_cause), 32'd2);
    check("to_valid", 32'(rdata_valid), 32'd0);
    check("to_stall_done", 32'(stall), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = 32'h12345678;
    step();
    bus_if.bus_rvalid_i = 1'b0;
    check("stray_valid", 32'(rdata_valid), 32'd0);
    check("stray_state", 32'(dbg_state), 32'd0);

    // Asynchronous reset in WAIT1.
    drive(1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
    step();
    bus_if.bus_gnt_i = 1'b1;
    step();
    bus_if.bus_gnt_i = 1'b0;
    check("ar_state_wait1", 32'(dbg_state), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_rdata", rdata, 32'd0);
    check("ar_state", 32'(dbg_state), 32'd0);
    check("ar_req", 32'(bus_if.bus_req_o), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("ar_idle_after", 32'(dbg_state), 32'd0);
    check("ar_stall_after", 32'(stall), 32'd0);
    single("lw_post", 1'b0, 32'h100, 32'h0, 3'b010, 4'hF, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 0);

    repeat (2) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
